// File: rtl/mul_sched_pkg.sv
// Shared encodings for the multiplier scheduler: op codes, FSM states, datapath width.
package mul_sched_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_GO   = 3'd2,
    S_WAIT = 3'd3,
    S_FIX  = 3'd4,
    S_RESP = 3'd5
  } state_e;
endpackage

// File: rtl/mul_fixup.sv
// Turns the signed x signed product words into the MUL/MULH/MULHSU/MULHU result.
module mul_fixup
  import mul_sched_pkg::*;
(
  input  mul_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] res
);
  logic [XLEN-1:0] adj_a, adj_b;

  // An operand read as unsigned gains 2^32 when its sign bit is set,
  // which adds the other operand into the high word.
  always_comb begin
    adj_a = b[XLEN-1] ? a : '0;
    adj_b = a[XLEN-1] ? b : '0;
    case (op)
      OP_MUL:    res = lo;
      OP_MULH:   res = hi;
      OP_MULHSU: res = hi + adj_a;
      default:   res = hi + adj_a + adj_b;
    endcase
  end
endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one iterative Booth multiplier between two requesters.
// Optional result reuse cache enabled by defining MUL_SCHED_REUSE_EN.
module mul_sched #(
  parameter int WAIT_MAX = 40,
  parameter int XLEN     = 32
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [1:0]        iReqValid,
  output logic [1:0]        oReqReady,
  input  logic [3:0]        iReqOp,
  input  logic [2*XLEN-1:0] iReqA,
  input  logic [2*XLEN-1:0] iReqB,
  output logic [1:0]        oRspValid,
  input  logic [1:0]        iRspReady,
  output logic [XLEN-1:0]   oRspData,
  output logic              oTimeout,
  output logic              oBusy,
  output logic              oMulReset_b,
  output logic              oMulGo,
  output logic [XLEN-1:0]   oMand,
  output logic [XLEN-1:0]   oMer,
  input  logic              iMulDone,
  input  logic [XLEN-1:0]   iMulHi,
  input  logic [XLEN-1:0]   iMulLo
);
  import mul_sched_pkg::*;

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_e          state_q, state_d;
  mul_op_e         op_q, op_d;
  logic            last_q, last_d, gnt_q, gnt_d, tmo_q, tmo_d;
  logic            gnt_c, hit;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rsp_q, rsp_d;
  logic [XLEN-1:0] req_a, req_b, hi_src, lo_src, fix_res;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign gnt_c = (&iReqValid) ? ~last_q : iReqValid[1];
  assign req_a = gnt_c ? iReqA[2*XLEN-1:XLEN] : iReqA[XLEN-1:0];
  assign req_b = gnt_c ? iReqB[2*XLEN-1:XLEN] : iReqB[XLEN-1:0];

`ifdef MUL_SCHED_REUSE_EN
  logic [XLEN-1:0] ca_q, ca_d, cb_q, cb_d, ch_q, ch_d, cl_q, cl_d;
  logic            cv_q, cv_d;
  assign hit    = cv_q && (req_a == ca_q) && (req_b == cb_q);
  assign hi_src = ch_q;
  assign lo_src = cl_q;
`else
  assign hit    = 1'b0;
  assign hi_src = iMulHi;
  assign lo_src = iMulLo;
`endif

  mul_fixup u_fixup (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .hi (hi_src),
    .lo (lo_src),
    .res(fix_res)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_d       = rsp_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    oReqReady   = 2'b00;
    oMulGo      = 1'b0;
    oMulReset_b = 1'b1;
`ifdef MUL_SCHED_REUSE_EN
    ca_d = ca_q;
    cb_d = cb_q;
    ch_d = ch_q;
    cl_d = cl_q;
    cv_d = cv_q;
`endif
    case (state_q)
      S_IDLE: begin
        oMulReset_b = 1'b0;
        if (|iReqValid) begin
          oReqReady = gnt_c ? 2'b10 : 2'b01;
          op_d      = mul_op_e'(iReqOp[2*gnt_c +: 2]);
          a_d       = req_a;
          b_d       = req_b;
          gnt_d     = gnt_c;
          last_d    = gnt_c;
          state_d   = hit ? S_FIX : S_CLR;
        end
      end
      // The multiplier's done flag is sticky, so every op starts from a clear.
      S_CLR: begin
        oMulReset_b = 1'b0;
        state_d     = S_GO;
      end
      S_GO: begin
        oMulGo  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (iMulDone) begin
          state_d = S_FIX;
`ifdef MUL_SCHED_REUSE_EN
          ca_d = a_q;
          cb_d = b_q;
          ch_d = iMulHi;
          cl_d = iMulLo;
          cv_d = 1'b1;
`endif
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          rsp_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
`ifdef MUL_SCHED_REUSE_EN
          cv_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        rsp_d   = fix_res;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (iRspReady[gnt_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef MUL_SCHED_REUSE_EN
  always_ff @(posedge iClk) begin
    if (iReset) begin
      ca_q <= '0;
      cb_q <= '0;
      ch_q <= '0;
      cl_q <= '0;
      cv_q <= 1'b0;
    end else begin
      ca_q <= ca_d;
      cb_q <= cb_d;
      ch_q <= ch_d;
      cl_q <= cl_d;
      cv_q <= cv_d;
    end
  end
`endif

  assign oRspValid = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign oRspData  = rsp_q;
  assign oTimeout  = tmo_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oMand     = a_q;
  assign oMer      = b_q;
endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched: random traffic against a product-level reference model.
module tb_mul_sched;
  localparam int WAIT_MAX = 40;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic [1:0]  iReqValid = '0;
  logic [1:0]  oReqReady;
  logic [3:0]  iReqOp = '0;
  logic [63:0] iReqA = '0;
  logic [63:0] iReqB = '0;
  logic [1:0]  oRspValid;
  logic [1:0]  iRspReady = '0;
  logic [31:0] oRspData;
  logic        oTimeout, oBusy, oMulReset_b, oMulGo;
  logic [31:0] oMand, oMer;
  logic        iMulDone = 1'b0;
  logic [31:0] iMulHi = '0;
  logic [31:0] iMulLo = '0;

  mul_sched #(.WAIT_MAX(WAIT_MAX), .XLEN(32)) dut (
    .iClk(iClk), .iReset(iReset), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqOp(iReqOp), .iReqA(iReqA), .iReqB(iReqB), .oRspValid(oRspValid),
    .iRspReady(iRspReady), .oRspData(oRspData), .oTimeout(oTimeout), .oBusy(oBusy),
    .oMulReset_b(oMulReset_b), .oMulGo(oMulGo), .oMand(oMand), .oMer(oMer),
    .iMulDone(iMulDone), .iMulHi(iMulHi), .iMulLo(iMulLo)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          port;
    logic [31:0] data;
    bit          tmo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, tmo_seen = 0, tmo_exp = 0;
  bit   m_last = 1'b1;
  bit   force_hang = 1'b0, hold_rsp = 1'b0;
  bit   cur_hang = 1'b0;
  int   cur_lat = 1;
  bit   acc_pend [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference result straight from the ISA definition of each op.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb2;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    case (op)
      2'd0, 2'd1: p = sa * sb2;
      2'd2:       p = sa * $signed({32'd0, b});
      default:    p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: signed product, done (sticky) cur_lat cycles after go, cleared by reset_b low.
  initial begin
    bit rb, go;
    logic [31:0] mand, mer;
    logic signed [63:0] prod;
    int rem;
    rem = 0;
    prod = '0;
    forever begin
      @(negedge iClk);
      rb = oMulReset_b; go = oMulGo; mand = oMand; mer = oMer;
      @(posedge iClk); #1;
      if (!rb) begin
        iMulDone = 1'b0; rem = 0;
      end else if (go) begin
        prod   = $signed({{32{mand[31]}}, mand}) * $signed({{32{mer[31]}}, mer});
        iMulHi = $urandom; iMulLo = $urandom;
        rem    = 0;
        if (!cur_hang) begin
          if (cur_lat == 1) begin
            iMulDone = 1'b1; iMulHi = prod[63:32]; iMulLo = prod[31:0];
          end else rem = cur_lat - 1;
        end
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          iMulDone = 1'b1; iMulHi = prod[63:32]; iMulLo = prod[31:0];
        end
      end
    end
  end

  // Acceptance (pushes expectations) and response monitor (pops and compares).
  always @(negedge iClk) begin
    bit          g, prev_vld, prev_rb, prev_busy;
    logic [1:0]  prev_rv, op;
    logic [31:0] prev_data, a, b;
    exp_t        e;
    cyc++;
    if (iReset) begin
      prev_vld = 1'b0; prev_rb = 1'b0; prev_busy = 1'b0;
    end else begin
      check("req_ready_not_both", oReqReady != 2'b11, oReqReady, 0);
      if (oBusy) check("req_ready_while_busy", oReqReady == 2'b00, oReqReady, 0);
      if (oReqReady != 2'b00) begin
        g = (&iReqValid) ? ~m_last : iReqValid[1];
        check("grant", oReqReady == (g ? 2'b10 : 2'b01), oReqReady, g ? 2 : 1);
        op = iReqOp[2*int'(g) +: 2];
        a  = iReqA[32*int'(g) +: 32];
        b  = iReqB[32*int'(g) +: 32];
        cur_hang = force_hang;
        cur_lat  = $urandom_range(1, 6);
        e.port = int'(g);
        e.tmo  = cur_hang;
        e.data = cur_hang ? 32'd0 : ref_res(op, a, b);
        e.lat  = cur_hang ? (WAIT_MAX + 3) : (cur_lat + 4);
        e.acc  = cyc;
        sb.push_back(e);
        grant_log.push_back(int'(oReqReady[1]));
        acc_pend[g] = 1'b1;
        m_last = g;
      end
      if (oMulGo)
        check("clr_one_cycle_before_go", !prev_rb && prev_busy && oMulReset_b, {prev_rb, prev_busy, oMulReset_b}, 3'b011);
      if (oRspValid != 2'b00) begin
        if (!prev_vld) begin
          if (sb.size() == 0) check("unexpected_rsp", 1'b0, oRspValid, 0);
          else begin
            e = sb.pop_front();
            check("rsp_port", oRspValid == (e.port ? 2'b10 : 2'b01), oRspValid, e.port ? 2 : 1);
            check("rsp_data", oRspData == e.data, oRspData, e.data);
            check("rsp_latency", (cyc - e.acc) == e.lat, cyc - e.acc, e.lat);
            check("rsp_timeout_flag", oTimeout == e.tmo, oTimeout, e.tmo);
            if (e.tmo) tmo_exp++;
          end
        end else begin
          check("rsp_stable", oRspValid == prev_rv && oRspData == prev_data, {oRspValid, oRspData}, {prev_rv, prev_data});
        end
      end
      if (oTimeout) begin
        tmo_seen++;
        if (!(oRspValid != 2'b00 && !prev_vld)) check("timeout_spurious", 1'b0, oTimeout, 0);
      end
      prev_vld  = (oRspValid != 2'b00);
      prev_rv   = oRspValid;
      prev_data = oRspData;
      prev_rb   = oMulReset_b;
      prev_busy = oBusy;
    end
  end

  task automatic tick();
    @(posedge iClk); #1;
    for (int p = 0; p < 2; p++)
      if (acc_pend[p]) begin iReqValid[p] = 1'b0; acc_pend[p] = 1'b0; end
    iRspReady = hold_rsp ? 2'b00 : 2'($urandom_range(0, 3));
  endtask

  task automatic issue(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (iReqValid[p] && n < 500) begin tick(); n++; end
    if (iReqValid[p]) check("issue_slot_timeout", 1'b0, n, 500);
    else begin
      iReqOp[2*p +: 2] = op;
      iReqA[32*p +: 32] = a;
      iReqB[32*p +: 32] = b;
      iReqValid[p] = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || oBusy || iReqValid != 2'b00) && n < 2000) begin tick(); n++; end
    check("drain", n < 2000, n, 2000);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
    return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
  endfunction

  initial begin
    int n, gl0;
    repeat (3) tick();
    check("rst_req_ready", oReqReady == 2'b00, oReqReady, 0);
    check("rst_rsp_valid", oRspValid == 2'b00, oRspValid, 0);
    check("rst_rsp_data", oRspData == 32'd0, oRspData, 0);
    check("rst_timeout", oTimeout == 1'b0, oTimeout, 0);
    check("rst_busy", oBusy == 1'b0, oBusy, 0);
    check("rst_go", oMulGo == 1'b0, oMulGo, 0);
    check("rst_mul_reset_b", oMulReset_b == 1'b0, oMulReset_b, 0);
    iReset = 1'b0;
    tick();

    // Directed ops from the plan, then strict alternation with both ports valid.
    issue(0, 2'd0, 32'd7, 32'hfffffffd);
    drain();
    issue(1, 2'd1, 32'hffffffff, 32'hffffffff);
    issue(1, 2'd2, 32'hffffffff, 32'hffffffff);
    issue(1, 2'd3, 32'hffffffff, 32'hffffffff);
    drain();
    gl0 = grant_log.size();
    issue(0, 2'd3, 32'd5, 32'd6);
    issue(1, 2'd0, 32'd5, 32'd6);
    issue(0, 2'd2, 32'h80000000, 32'hffffffff);
    issue(1, 2'd1, 32'h80000000, 32'h80000000);
    drain();
    for (int i = 0; i < 4; i++)
      check("alternate_grant", grant_log.size() > gl0 + i && grant_log[gl0 + i] == (i % 2),
            (grant_log.size() > gl0 + i) ? grant_log[gl0 + i] : -1, i % 2);

    // Multiplier never finishes.
    force_hang = 1'b1;
    issue(0, 2'd0, 32'd3, 32'd4);
    drain();
    force_hang = 1'b0;

    // Consumer stalls for 10 cycles.
    hold_rsp = 1'b1;
    issue(1, 2'd3, 32'hdeadbeef, 32'h12345678);
    n = 0;
    while (oRspValid == 2'b00 && n < 100) begin tick(); n++; end
    check("hold_rsp_arrives", n < 100, n, 100);
    repeat (10) tick();
    check("hold_rsp_still_valid", oRspValid == 2'b10, oRspValid, 2);
    hold_rsp = 1'b0;
    drain();

    for (int k = 0; k < 60; k++) begin
      issue($urandom_range(0, 1), 2'($urandom_range(0, 3)), pick(), pick());
      if ($urandom_range(0, 2) == 0) tick();
    end
    drain();

    // Reset while waiting on the multiplier: no response, everything back to reset values.
    force_hang = 1'b1;
    issue(0, 2'd1, 32'd9, 32'd9);
    n = 0;
    while (!oMulGo && n < 50) begin tick(); n++; end
    check("reach_go", n < 50, n, 50);
    repeat (3) tick();
    force_hang = 1'b0;
    iReqValid = 2'b00;
    iReset = 1'b1;
    tick();
    sb.delete();
    m_last = 1'b1;
    check("midrst_req_ready", oReqReady == 2'b00, oReqReady, 0);
    check("midrst_rsp_valid", oRspValid == 2'b00, oRspValid, 0);
    check("midrst_rsp_data", oRspData == 32'd0, oRspData, 0);
    check("midrst_timeout", oTimeout == 1'b0, oTimeout, 0);
    check("midrst_busy", oBusy == 1'b0, oBusy, 0);
    check("midrst_go", oMulGo == 1'b0, oMulGo, 0);
    check("midrst_mul_reset_b", oMulReset_b == 1'b0, oMulReset_b, 0);
    iReset = 1'b0;
    tick();
    gl0 = grant_log.size();
    issue(1, 2'd0, 32'd11, 32'd13);
    issue(0, 2'd0, 32'd17, 32'd19);
    drain();
    check("post_reset_first_grant", grant_log.size() > gl0 && grant_log[gl0] == 0,
          (grant_log.size() > gl0) ? grant_log[gl0] : -1, 0);

    check("timeout_pulse_count", tmo_seen == tmo_exp && tmo_exp == 1, tmo_seen, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_chk, n_pass);
    $fatal(1);
  end
endmodule
